// File: rtl/blit_vram_if.sv
// Blit request port between a fill/copy engine and vram_arb.
// The engine drives the request side; the arbiter returns ack.
interface blit_vram_if;
  logic        sel;
  logic        ack;
  logic        wr;
  logic [3:0]  wr_mask;
  logic [15:0] addr;
  logic [15:0] data;

  modport master (output sel, output wr, output wr_mask, output addr, output data, input ack);
  modport slave  (input sel, input wr, input wr_mask, input addr, input data, output ack);
endinterface

// File: rtl/blit_rect_fill.sv
// Rectangle fill engine: writes one masked 16-bit word over a W x H block of VRAM,
// one word per arbiter ack, walking columns then rows with a programmable stride.
module blit_rect_fill #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [15:0]      dst_addr_i,
  input  logic [15:0]      dst_stride_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic [CNT_W-1:0] height_i,
  input  logic [15:0]      fill_data_i,
  input  logic [3:0]       wr_mask_i,
  output logic             busy_o,
  output logic             done_o,
  blit_vram_if.master      vram
);

  typedef enum logic [1:0] {IDLE, WRITE, EMPTY, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] col;
  logic [CNT_W-1:0] row;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] height;
  logic [15:0]      addr;
  logic [15:0]      row_base;
  logic [15:0]      stride;
  logic [15:0]      data;
  logic [3:0]       mask;

  logic accept;
  logic empty_req;
  logic last_col;
  logic last_row;
  logic take;

  always_comb begin
    // DONE behaves as IDLE for start acceptance, giving a one-cycle gap between fills
    accept    = start_i && ((state == IDLE) || (state == DONE));
    empty_req = (width_i == '0) || (height_i == '0);
    last_col  = (col == width - CNT_W'(1));
    last_row  = (row == height - CNT_W'(1));
    take      = (state == WRITE) && vram.ack;
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nxt = empty_req ? EMPTY : WRITE;
        else        state_nxt = IDLE;
      end
      EMPTY: state_nxt = DONE;
      WRITE: begin
        if (abort_i || (take && last_col && last_row)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Operands are captured at start so the inputs may change during the fill.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      col      <= '0;
      row      <= '0;
      width    <= '0;
      height   <= '0;
      addr     <= '0;
      row_base <= '0;
      stride   <= '0;
      data     <= '0;
      mask     <= '0;
    end else if (accept) begin
      col      <= '0;
      row      <= '0;
      width    <= width_i;
      height   <= height_i;
      addr     <= dst_addr_i;
      row_base <= dst_addr_i;
      stride   <= dst_stride_i;
      data     <= fill_data_i;
      mask     <= wr_mask_i;
    end else if (take) begin
      if (!last_col) begin
        col  <= col + CNT_W'(1);
        addr <= addr + 16'd1;
      end else if (!last_row) begin
        col      <= '0;
        row      <= row + CNT_W'(1);
        row_base <= row_base + stride;
        addr     <= row_base + stride;
      end
    end
  end

  assign vram.sel     = (state == WRITE);
  assign vram.wr      = (state == WRITE);
  assign vram.addr    = addr;
  assign vram.data    = data;
  assign vram.wr_mask = mask;
  assign busy_o       = (state == WRITE) || (state == EMPTY);
  assign done_o       = (state == DONE);

endmodule

// File: tb/tb_blit_rect_fill.sv
// Bench for blit_rect_fill: a queue of expected write addresses per fill, checked every cycle.
module tb_blit_rect_fill;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic             start_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [15:0]      dst_addr_i = '0;
  logic [15:0]      dst_stride_i = '0;
  logic [CNT_W-1:0] width_i = '0;
  logic [CNT_W-1:0] height_i = '0;
  logic [15:0]      fill_data_i = '0;
  logic [3:0]       wr_mask_i = '0;
  logic             busy_o;
  logic             done_o;

  always #5 clk = ~clk;

  blit_vram_if vif();

  blit_rect_fill #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
    .dst_addr_i(dst_addr_i), .dst_stride_i(dst_stride_i),
    .width_i(width_i), .height_i(height_i),
    .fill_data_i(fill_data_i), .wr_mask_i(wr_mask_i),
    .busy_o(busy_o), .done_o(done_o), .vram(vif)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  int          n_writes = 0;
  logic [15:0] exp_q[$];
  logic [15:0] act_log[$];
  logic [15:0] exp_data = '0;
  logic [3:0]  exp_mask = '0;
  bit          fill_live = 1'b0;
  bit          done_due = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: a fill is the ordered list dst + r*stride + c (mod 2^16); sel is up while words
  // remain, busy while the fill lives, done the cycle after it ends.
  always @(negedge clk) begin
    logic exp_sel;
    if (!reset_i) begin
      exp_sel = fill_live && (exp_q.size() > 0);
      chk("sel",  32'(vif.sel), 32'(exp_sel));
      chk("wr",   32'(vif.wr),  32'(exp_sel));
      chk("busy", 32'(busy_o),  32'(fill_live));
      chk("done", 32'(done_o),  32'(done_due));
      done_due = 1'b0;
      if (vif.sel && exp_q.size() > 0) begin
        chk("addr", 32'(vif.addr),    32'(exp_q[0]));
        chk("data", 32'(vif.data),    32'(exp_data));
        chk("mask", 32'(vif.wr_mask), 32'(exp_mask));
        if (vif.ack) begin
          act_log.push_back(vif.addr);
          void'(exp_q.pop_front());
          n_writes++;
        end
        if (abort_i) exp_q.delete();
      end
      if (fill_live && exp_q.size() == 0) begin
        fill_live = 1'b0;
        done_due  = 1'b1;
      end
    end
  end

  task automatic scramble();
    dst_addr_i   = 16'($urandom);
    dst_stride_i = 16'($urandom);
    width_i      = CNT_W'($urandom);
    height_i     = CNT_W'($urandom);
    fill_data_i  = 16'($urandom);
    wr_mask_i    = 4'($urandom);
  endtask

  // Called just after a posedge while the DUT is idle or in DONE; returns at T+1 (+1).
  task automatic start_fill(input logic [15:0] dst, input logic [15:0] stride,
                            input logic [15:0] w, input logic [15:0] h,
                            input logic [15:0] d, input logic [3:0] m);
    dst_addr_i = dst; dst_stride_i = stride; width_i = w; height_i = h;
    fill_data_i = d; wr_mask_i = m; start_i = 1'b1;
    exp_data = d; exp_mask = m;
    act_log.delete();
    for (int r = 0; r < int'(h); r++)
      for (int c = 0; c < int'(w); c++)
        exp_q.push_back(16'(int'(dst) + r * int'(stride) + c));
    @(posedge clk); #1;
    start_i = 1'b0;
    scramble();
    fill_live = 1'b1;
  endtask

  task automatic run_until_done(input bit rand_ack, input int abort_after, input bit abort_ack,
                                input bit busy_start, output int cycles, output int writes,
                                output bit aborted);
    int base;
    bit got;
    base = n_writes; cycles = 0; aborted = 1'b0; got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      vif.ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!aborted && abort_after >= 0 && (n_writes - base) == abort_after && vif.sel) begin
        abort_i = 1'b1;
        vif.ack = abort_ack;
        aborted = 1'b1;
      end
      if (busy_start && busy_o && $urandom_range(0, 3) == 0) begin
        scramble();
        start_i = 1'b1;
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      abort_i = 1'b0;
      cycles++;
      got = done_o;
    end
    writes = n_writes - base;
    chk("done_reached", 32'(got), 32'd1);
  endtask

  logic [15:0] t2_addr [6];
  logic [15:0] t4_addr [4];

  initial begin
    int cyc, wr_cnt, w, h, k;
    bit ab, aack;

    t2_addr = '{16'h0100, 16'h0101, 16'h0102, 16'h0150, 16'h0151, 16'h0152};
    t4_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    vif.ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel",  32'(vif.sel),     32'd0);
    chk("rst_addr", 32'(vif.addr),    32'd0);
    chk("rst_data", 32'(vif.data),    32'd0);
    chk("rst_mask", 32'(vif.wr_mask), 32'd0);
    chk("rst_busy", 32'(busy_o),      32'd0);
    chk("rst_done", 32'(done_o),      32'd0);
    reset_i = 1'b0;
    @(posedge clk); #1;

    // 1: single row, ack every cycle
    start_fill(16'h1000, 16'h0000, 16'd4, 16'd1, 16'hABCD, 4'hF);
    chk("t1_sel_t1",  32'(vif.sel),  32'd1);
    chk("t1_addr_t1", 32'(vif.addr), 32'h1000);
    chk("t1_busy_t1", 32'(busy_o),   32'd1);
    run_until_done(1'b0, -1, 1'b0, 1'b0, cyc, wr_cnt, ab);
    chk("t1_done_latency", 32'(cyc), 32'd4);
    chk("t1_writes", 32'(wr_cnt), 32'd4);
    @(posedge clk); #1;

    // 2: two rows with stride
    start_fill(16'h0100, 16'h0050, 16'd3, 16'd2, 16'h5A5A, 4'h6);
    chk("t2_model_row1", 32'(exp_q[3]), 32'h0150);
    run_until_done(1'b1, -1, 1'b0, 1'b0, cyc, wr_cnt, ab);
    chk("t2_writes", 32'(wr_cnt), 32'd6);
    for (int i = 0; i < 6 && i < act_log.size(); i++) chk("t2_addr_seq", 32'(act_log[i]), 32'(t2_addr[i]));

    // 3: ack withheld mid-row
    start_fill(16'h2000, 16'h0020, 16'd6, 16'd2, 16'h1234, 4'h9);
    repeat (2) begin vif.ack = 1'b1; @(posedge clk); #1; end
    vif.ack = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("t3_hold_sel",  32'(vif.sel),  32'd1);
      chk("t3_hold_addr", 32'(vif.addr), 32'h2002);
      chk("t3_hold_data", 32'(vif.data), 32'h1234);
    end
    run_until_done(1'b0, -1, 1'b0, 1'b0, cyc, wr_cnt, ab);
    chk("t3_writes_after_hold", 32'(wr_cnt), 32'd10);

    // 4: address wrap, started back-to-back on the done cycle
    start_fill(16'hFFFE, 16'h0000, 16'd4, 16'd1, 16'hC0DE, 4'h3);
    chk("t4_model_wrap", 32'(exp_q[2]), 32'h0000);
    run_until_done(1'b0, -1, 1'b0, 1'b0, cyc, wr_cnt, ab);
    for (int i = 0; i < 4 && i < act_log.size(); i++) chk("t4_addr_seq", 32'(act_log[i]), 32'(t4_addr[i]));
    @(posedge clk); #1;

    // 5: empty fill, then a fill started on its done cycle
    start_fill(16'h3000, 16'h0010, 16'd0, 16'd7, 16'hFFFF, 4'hF);
    chk("t5_busy_t1", 32'(busy_o),  32'd1);
    chk("t5_sel_t1",  32'(vif.sel), 32'd0);
    @(posedge clk); #1;
    chk("t5_done_t2", 32'(done_o), 32'd1);
    start_fill(16'h3000, 16'h0010, 16'd2, 16'd2, 16'h0F0F, 4'hA);
    chk("t5_accept_on_done", 32'(vif.sel), 32'd1);
    run_until_done(1'b1, -1, 1'b0, 1'b0, cyc, wr_cnt, ab);
    chk("t5_writes", 32'(wr_cnt), 32'd4);

    // abort in idle has no effect
    @(posedge clk); #1;
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    chk("idle_abort_busy", 32'(busy_o), 32'd0);
    chk("idle_abort_done", 32'(done_o), 32'd0);

    // 6: abort after 2 acks (with stray starts), abort coincident with an ack
    start_fill(16'h4000, 16'h0100, 16'd4, 16'd2, 16'h7777, 4'h5);
    run_until_done(1'b1, 2, 1'b0, 1'b1, cyc, wr_cnt, ab);
    chk("t6_abort_writes", 32'(wr_cnt), 32'd2);
    @(posedge clk); #1;
    start_fill(16'h4000, 16'h0100, 16'd4, 16'd2, 16'h8888, 4'hC);
    run_until_done(1'b0, 2, 1'b1, 1'b0, cyc, wr_cnt, ab);
    chk("t6_abort_ack_writes", 32'(wr_cnt), 32'd3);
    @(posedge clk); #1;

    // reset mid-fill: outputs clear, no done afterwards
    start_fill(16'h5000, 16'h0040, 16'd5, 16'd3, 16'h9999, 4'hF);
    repeat (2) begin vif.ack = 1'b1; @(posedge clk); #1; end
    reset_i = 1'b1;
    exp_q.delete(); fill_live = 1'b0; done_due = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_sel",  32'(vif.sel),     32'd0);
    chk("mid_rst_addr", 32'(vif.addr),    32'd0);
    chk("mid_rst_data", 32'(vif.data),    32'd0);
    chk("mid_rst_mask", 32'(vif.wr_mask), 32'd0);
    chk("mid_rst_busy", 32'(busy_o),      32'd0);
    chk("mid_rst_done", 32'(done_o),      32'd0);
    reset_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // randomized fills
    for (int n = 0; n < 30; n++) begin
      w = $urandom_range(0, 5);
      h = $urandom_range(0, 4);
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
      aack = 1'($urandom_range(0, 1));
      start_fill(($urandom_range(0, 2) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF)) : 16'($urandom),
                 16'($urandom), 16'(w), 16'(h), 16'($urandom), 4'($urandom));
      run_until_done(1'b1, k, aack, 1'($urandom_range(0, 1)), cyc, wr_cnt, ab);
      chk("rnd_writes", 32'(wr_cnt), ab ? 32'(k + int'(aack)) : 32'(w * h));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
